fir_tdm_scheduler: RTL and testbench

- Time-division scheduler that shares one MAC FIR core (ND/DIN/RFD/RDY/DOUT handshake) between NUM_CH independent sample streams at 3.84 Msps each, on the 30.72 MHz system clock.
- Buffers one sample per channel, issues ND pulses round-robin with a minimum spacing, tags each issue with its channel, and routes core outputs back to per-channel output registers.
- Sits between the channel sample sources and the FIR core.

---
 rtl/fir_tdm_pkg.sv | 23 ++
 rtl/fir_tag_fifo.sv | 46 ++++
 rtl/fir_tdm_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_fir_tdm_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tdm_pkg.sv
// Shared types and constants for the time-division FIR core scheduler.
package fir_tdm_pkg;

    localparam int DW_DEFAULT     = 16;
    localparam int NUM_CH_DEFAULT = 2;
    localparam int SYS_CLK_HZ     = 30_720_000;
    localparam int CHIP_DIV       = 8;
    // 3.84 Msps per channel: each channel presents at most one sample every CHIP_DIV clocks
    localparam int CH_SAMPLE_HZ   = SYS_CLK_HZ / CHIP_DIV;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_width(NUM_CH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fir_tag_fifo.sv
// In-flight channel tag FIFO: one entry per sample handed to the core, popped on core output.
module fir_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_tag,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_tag,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_tag;
    end

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_pop_tag = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Shares one handshake FIR core between NUM_CH sample streams: buffer, round-robin issue, tag, route back.
//   state | meaning
//   IDLE  | waiting for a full buffer, core_rfd and tag FIFO space
//   ISSUE | core_nd high for this single cycle
//   GAP   | enforcing minimum spacing before the next issue
module fir_tdm_scheduler
    import fir_tdm_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int ISSUE_GAP = 4,
    parameter int TAG_DEPTH = 4
)(
    input  logic                 clk_30p72MHz,
    input  logic                 reset,
    input  logic [NUM_CH*DW-1:0] ch_din,
    input  logic [NUM_CH-1:0]    ch_valid,
    output logic [NUM_CH-1:0]    ch_ready,
    output logic                 core_nd,
    output logic [DW-1:0]        core_din,
    input  logic                 core_rfd,
    input  logic                 core_rdy,
    input  logic [DW-1:0]        core_dout,
    output logic [NUM_CH*DW-1:0] ch_dout,
    output logic [NUM_CH-1:0]    ch_dout_valid,
    output logic [NUM_CH-1:0]    overrun,
    output logic                 tag_err
);

    localparam int TAG_W = ch_width(NUM_CH);
    localparam int GAP_W = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((ISSUE_GAP > 1) ? (ISSUE_GAP - 2) : 0);

    sched_state_t        r_state;
    sched_state_t        w_next_state;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [GAP_W-1:0]    w_gap_cnt_next;
    logic [TAG_W-1:0]    r_rr;
    logic [NUM_CH-1:0]   r_full;
    logic [DW-1:0]       r_buf [NUM_CH];
    logic                r_core_nd;
    logic [DW-1:0]       r_core_din;
    logic [NUM_CH*DW-1:0] r_ch_dout;
    logic [NUM_CH-1:0]   r_ch_dout_valid;
    logic [NUM_CH-1:0]   r_overrun;
    logic                r_tag_err;

    logic                w_grant_any;
    logic [TAG_W-1:0]    w_grant_idx;
    logic                w_issue;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic [TAG_W-1:0]    w_tag;

    function automatic logic [TAG_W-1:0] rr_offset(input logic [TAG_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return TAG_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest full channel at/after r_rr wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_full[rr_offset(r_rr, i)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = rr_offset(r_rr, i);
            end
        end
    end

    assign w_issue = (r_state == IDLE) && w_grant_any && core_rfd && !w_fifo_full;

    always_comb begin
        w_next_state   = r_state;
        w_gap_cnt_next = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (w_issue) w_next_state = ISSUE;
            end
            ISSUE: begin
                if (ISSUE_GAP > 1) begin
                    w_next_state   = GAP;
                    w_gap_cnt_next = GAP_INIT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_next_state   = IDLE;
                    w_gap_cnt_next = '0;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state   = IDLE;
                w_gap_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_30p72MHz or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gap_cnt  <= '0;
            r_rr       <= '0;
            r_core_nd  <= 1'b0;
            r_core_din <= '0;
        end else begin
            r_state   <= w_next_state;
            r_gap_cnt <= w_gap_cnt_next;
            r_core_nd <= w_issue;
            if (w_issue) begin
                r_core_din <= r_buf[w_grant_idx];
                r_rr       <= (w_grant_idx == TAG_W'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    // A sample arriving on the cycle its buffer is issued refills it rather than counting as overrun.
    always_ff @(posedge clk_30p72MHz or posedge reset) begin
        if (reset) begin
            r_full    <= '0;
            r_overrun <= '0;
            for (int k = 0; k < NUM_CH; k++) r_buf[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_issue && (w_grant_idx == TAG_W'(k))) begin
                    r_full[k] <= ch_valid[k];
                    if (ch_valid[k]) r_buf[k] <= ch_din[k*DW +: DW];
                end else if (ch_valid[k]) begin
                    if (r_full[k]) begin
                        r_overrun[k] <= 1'b1;
                    end else begin
                        r_buf[k]  <= ch_din[k*DW +: DW];
                        r_full[k] <= 1'b1;
                    end
                end
            end
        end
    end

    fir_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (TAG_W)
    ) u_tag_fifo (
        .i_clk      (clk_30p72MHz),
        .i_rst      (reset),
        .i_push     (w_issue),
        .i_push_tag (w_grant_idx),
        .i_pop      (core_rdy),
        .o_pop_tag  (w_tag),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign w_pop = core_rdy && !w_fifo_empty;

    always_ff @(posedge clk_30p72MHz or posedge reset) begin
        if (reset) begin
            r_ch_dout       <= '0;
            r_ch_dout_valid <= '0;
            r_tag_err       <= 1'b0;
        end else begin
            r_ch_dout_valid <= '0;
            if (w_pop) begin
                r_ch_dout[int'(w_tag)*DW +: DW] <= core_dout;
                r_ch_dout_valid[w_tag]           <= 1'b1;
            end
            if (core_rdy && w_fifo_empty) r_tag_err <= 1'b1;
        end
    end

    assign ch_ready      = ~r_full;
    assign core_nd       = r_core_nd;
    assign core_din      = r_core_din;
    assign ch_dout       = r_ch_dout;
    assign ch_dout_valid = r_ch_dout_valid;
    assign overrun       = r_overrun;
    assign tag_err       = r_tag_err;

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed bench for fir_tdm_scheduler with NUM_CH=2, ISSUE_GAP=4, hand-computed expectations.
module tb_fir_tdm_scheduler;

    localparam int NUM_CH = 2;
    localparam int DW     = 16;

    logic                 clk_30p72MHz = 1'b0;
    logic                 reset = 1'b0;
    logic [NUM_CH*DW-1:0] ch_din = '0;
    logic [NUM_CH-1:0]    ch_valid = '0;
    logic [NUM_CH-1:0]    ch_ready;
    logic                 core_nd;
    logic [DW-1:0]        core_din;
    logic                 core_rfd = 1'b1;
    logic                 core_rdy = 1'b0;
    logic [DW-1:0]        core_dout = '0;
    logic [NUM_CH*DW-1:0] ch_dout;
    logic [NUM_CH-1:0]    ch_dout_valid;
    logic [NUM_CH-1:0]    overrun;
    logic                 tag_err;

    int n_err = 0;
    int n_chk = 0;

    fir_tdm_scheduler #(
        .NUM_CH    (NUM_CH),
        .DW        (DW),
        .ISSUE_GAP (4),
        .TAG_DEPTH (4)
    ) dut (
        .clk_30p72MHz  (clk_30p72MHz),
        .reset         (reset),
        .ch_din        (ch_din),
        .ch_valid      (ch_valid),
        .ch_ready      (ch_ready),
        .core_nd       (core_nd),
        .core_din      (core_din),
        .core_rfd      (core_rfd),
        .core_rdy      (core_rdy),
        .core_dout     (core_dout),
        .ch_dout       (ch_dout),
        .ch_dout_valid (ch_dout_valid),
        .overrun       (overrun),
        .tag_err       (tag_err)
    );

    always #5 clk_30p72MHz = ~clk_30p72MHz;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_30p72MHz);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; returns at "cycle 0" with reset released.
    task automatic do_reset();
        ch_valid = '0;
        core_rdy = 1'b0;
        core_rfd = 1'b1;
        ch_din   = '0;
        #3 reset = 1'b1;
        @(posedge clk_30p72MHz);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected normal finish");
        $fatal(1);
    end

    initial begin
        int nd_cnt;
        logic exp_nd;
        logic [DW-1:0] exp_din;

        step(2);
        #3 reset = 1'b1;
        #1;
        chk("rst_nd", core_nd, 0);
        chk("rst_din", core_din, 0);
        chk("rst_dout", ch_dout, 0);
        chk("rst_dv", ch_dout_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_tagerr", tag_err, 0);
        chk("rst_ready", ch_ready, 2'b11);
        @(posedge clk_30p72MHz);
        #1 reset = 1'b0;

        // single channel
        ch_din = {16'h0000, 16'h1234};
        ch_valid = 2'b01;
        step();
        ch_valid = '0;
        chk("t1_ready_c1", ch_ready, 2'b10);
        chk("t1_nd_c1", core_nd, 0);
        step();
        chk("t1_nd_c2", core_nd, 1);
        chk("t1_din_c2", core_din, 16'h1234);
        chk("t1_ready_c2", ch_ready, 2'b11);
        step();
        chk("t1_nd_c3", core_nd, 0);
        core_rdy = 1'b1;
        core_dout = 16'h0ABC;
        step();
        core_rdy = 1'b0;
        chk("t1_dout0", ch_dout[15:0], 16'h0ABC);
        chk("t1_dv", ch_dout_valid, 2'b01);
        step();
        chk("t1_dv_clr", ch_dout_valid, 2'b00);
        chk("t1_dout0_hold", ch_dout[15:0], 16'h0ABC);

        // round robin
        do_reset();
        ch_din = {16'h2222, 16'h1111};
        ch_valid = 2'b11;
        step();
        ch_valid = '0;
        step();
        chk("t2_nd_c2", core_nd, 1);
        chk("t2_din_c2", core_din, 16'h1111);
        for (int c = 3; c <= 5; c++) begin
            step();
            chk("t2_nd_gap", core_nd, 0);
        end
        step();
        chk("t2_nd_c6", core_nd, 1);
        chk("t2_din_c6", core_din, 16'h2222);
        step();
        chk("t2_nd_c7", core_nd, 0);
        core_rdy = 1'b1;
        core_dout = 16'h000A;
        step();
        core_dout = 16'h000B;
        chk("t2_dv_c8", ch_dout_valid, 2'b01);
        chk("t2_dout0_c8", ch_dout[15:0], 16'h000A);
        step();
        core_rdy = 1'b0;
        chk("t2_dv_c9", ch_dout_valid, 2'b10);
        chk("t2_dout1_c9", ch_dout[31:16], 16'h000B);
        chk("t2_dout0_c9", ch_dout[15:0], 16'h000A);

        // overrun and back-pressure
        do_reset();
        core_rfd = 1'b0;
        ch_din = {16'h3333, 16'h0000};
        ch_valid = 2'b10;
        step();
        ch_valid = '0;
        nd_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            nd_cnt += int'(core_nd);
            step();
        end
        ch_din = {16'h4444, 16'h0000};
        ch_valid = 2'b10;
        nd_cnt += int'(core_nd);
        step();
        ch_valid = '0;
        nd_cnt += int'(core_nd);
        chk("t3_no_nd", nd_cnt, 0);
        chk("t3_overrun", overrun, 2'b10);
        chk("t3_ready", ch_ready, 2'b01);
        core_rfd = 1'b1;
        step();
        chk("t3_nd", core_nd, 1);
        chk("t3_din_first", core_din, 16'h3333);
        chk("t3_ready_after", ch_ready, 2'b11);
        nd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            nd_cnt += int'(core_nd);
        end
        chk("t3_single_issue", nd_cnt, 0);
        chk("t3_overrun_sticky", overrun, 2'b10);

        // tag error with nothing in flight
        do_reset();
        core_rdy = 1'b1;
        core_dout = 16'h5555;
        step();
        core_rdy = 1'b0;
        chk("t4_tagerr", tag_err, 1);
        chk("t4_dv", ch_dout_valid, 2'b00);
        chk("t4_dout", ch_dout, 0);
        step();
        chk("t4_tagerr_sticky", tag_err, 1);

        // tag FIFO full blocks the fifth issue until one output returns
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            exp_nd = 1'b0;
            exp_din = '0;
            case (c)
                2:  begin exp_nd = 1'b1; exp_din = 16'h0101; end
                6:  begin exp_nd = 1'b1; exp_din = 16'h0202; end
                10: begin exp_nd = 1'b1; exp_din = 16'h0303; end
                14: begin exp_nd = 1'b1; exp_din = 16'h0404; end
                26: begin exp_nd = 1'b1; exp_din = 16'h0505; end
                default: ;
            endcase
            if (c > 0) chk($sformatf("t5_nd_c%0d", c), core_nd, exp_nd);
            if (exp_nd) chk($sformatf("t5_din_c%0d", c), core_din, exp_din);
            if (c == 25) begin
                chk("t5_dv_c25", ch_dout_valid, 2'b01);
                chk("t5_dout0_c25", ch_dout[15:0], 16'h0A01);
            end
            ch_valid = '0;
            core_rdy = 1'b0;
            case (c)
                0:  begin ch_din = {16'h0202, 16'h0101}; ch_valid = 2'b11; end
                3:  begin ch_din = {16'h0000, 16'h0303}; ch_valid = 2'b01; end
                6:  begin ch_din = {16'h0404, 16'h0000}; ch_valid = 2'b10; end
                10: begin ch_din = {16'h0000, 16'h0505}; ch_valid = 2'b01; end
                24: begin core_rdy = 1'b1; core_dout = 16'h0A01; end
                default: ;
            endcase
            step();
        end
        ch_valid = '0;
        core_rdy = 1'b0;
        chk("t5_overrun", overrun, 2'b00);
        chk("t5_tagerr", tag_err, 0);

        // reset during GAP discards the in-flight tag
        do_reset();
        ch_din = {16'h0000, 16'h0600};
        ch_valid = 2'b01;
        step();
        ch_valid = '0;
        step();
        chk("t6_nd_c2", core_nd, 1);
        chk("t6_din_c2", core_din, 16'h0600);
        step();
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_nd", core_nd, 0);
        chk("t6_rst_din", core_din, 0);
        chk("t6_rst_ready", ch_ready, 2'b11);
        @(posedge clk_30p72MHz);
        #1 reset = 1'b0;
        core_rdy = 1'b1;
        core_dout = 16'h1357;
        step();
        core_rdy = 1'b0;
        chk("t6_tagerr", tag_err, 1);
        chk("t6_dv_none", ch_dout_valid, 2'b00);
        ch_din = {16'h0000, 16'h0777};
        ch_valid = 2'b01;
        step();
        ch_valid = '0;
        step();
        chk("t6_nd_new", core_nd, 1);
        chk("t6_din_new", core_din, 16'h0777);
        core_rdy = 1'b1;
        core_dout = 16'h2468;
        step();
        core_rdy = 1'b0;
        chk("t6_dv_new", ch_dout_valid, 2'b01);
        chk("t6_dout0_new", ch_dout[15:0], 16'h2468);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
